// File: rtl/accum16_pkg.sv
// Shared types and widths for the accum16 burst accumulator.
package accum16_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fulladd16.sv
// Combinational 16-bit ripple-carry adder built from per-bit full adders.
module fulladd16
    import accum16_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
    output logic [DATA_W-1:0] sum,
    output logic              c_out
);

    logic [DATA_W:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[DATA_W];

endmodule

// File: rtl/accum16.sv
// Burst accumulator: sums BURST_LEN handshaked operands through fulladd16 and
// presents the wrapped total plus a sticky carry flag until the consumer takes it.
module accum16
    import accum16_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

    state_e            state_q;
    logic [DATA_W-1:0] acc_q;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] sum_d;
    logic              cout_d;

    // Carry-out is only collected into the sticky flag, never fed back.
    fulladd16 u_add (
        .a     (acc_q),
        .b     (in_data),
        .c_in  (1'b0),
        .sum   (sum_d),
        .c_out (cout_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACC;
                        acc_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_q   <= sum_d;
                        carry_q <= carry_q | cout_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_accum16.sv
// Self-checking bench for accum16: directed scenarios plus randomized bursts
// compared against an arithmetic reference model.
module tb_accum16;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_carry, busy;
    logic [15:0] out_sum;

    logic        s1_start, s1_in_valid, s1_out_ready;
    logic [15:0] s1_in_data;
    logic        s1_in_ready, s1_out_valid, s1_out_carry, s1_busy;
    logic [15:0] s1_out_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accum16 #(.BURST_LEN(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ready (out_ready),
        .busy      (busy)
    );

    accum16 #(.BURST_LEN(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s1_start),
        .in_valid  (s1_in_valid),
        .in_data   (s1_in_data),
        .in_ready  (s1_in_ready),
        .out_valid (s1_out_valid),
        .out_sum   (s1_out_sum),
        .out_carry (s1_out_carry),
        .out_ready (s1_out_ready),
        .busy      (s1_busy)
    );

    // Reference: wrapped sum and "any step overflowed" using plain integers.
    function automatic void model(input logic [15:0] q[$], output logic [15:0] s, output logic c);
        int acc;
        acc = 0;
        c   = 1'b0;
        foreach (q[i]) begin
            acc = acc + int'(q[i]);
            if (acc > 65535) begin
                c   = 1'b1;
                acc = acc - 65536;
            end
        end
        s = acc[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (out_sum !== 16'h0)   begin errors++; $display("[TB] FAIL reset_out_sum got %h want 0000", out_sum); end
        checks++; if (out_carry !== 1'b0)  begin errors++; $display("[TB] FAIL reset_out_carry got %b want 0", out_carry); end
        checks++; if (s1_busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_s1_busy got %b want 0", s1_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL idle_after_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        pulse_start();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
        send(16'd1, 0);
        send(16'd2, 0);
        send(16'd3, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got %b want 0", out_valid); end
        send(16'd4, 0);
        checks++; if (out_valid !== 1'b1)    begin errors++; $display("[TB] FAIL basic_out_valid got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0)     begin errors++; $display("[TB] FAIL basic_done_in_ready got %b want 0", in_ready); end
        checks++; if (out_sum !== 16'h000A)  begin errors++; $display("[TB] FAIL basic_sum got %h want 000a", out_sum); end
        checks++; if (out_carry !== 1'b0)    begin errors++; $display("[TB] FAIL basic_carry got %b want 0", out_carry); end
        take_result();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_release_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL basic_release_busy got %b want 0", busy); end
    endtask

    task automatic test_carry();
        pulse_start();
        send(16'hFFFF, 0);
        send(16'h0001, 0);
        checks++; if (out_carry !== 1'b1) begin errors++; $display("[TB] FAIL carry_set got %b want 1", out_carry); end
        send(16'h0000, 0);
        send(16'h0000, 0);
        checks++; if (out_valid !== 1'b1)   begin errors++; $display("[TB] FAIL carry_out_valid got %b want 1", out_valid); end
        checks++; if (out_sum !== 16'h0000) begin errors++; $display("[TB] FAIL carry_sum got %h want 0000", out_sum); end
        checks++; if (out_carry !== 1'b1)   begin errors++; $display("[TB] FAIL carry_sticky got %b want 1", out_carry); end
        take_result();
    endtask

    task automatic test_gaps();
        pulse_start();
        send(16'd5, 2);
        send(16'd6, 2);
        send(16'd7, 2);
        tick();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL gaps_stall_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL gaps_stall_valid got %b want 0", out_valid); end
        send(16'd8, 1);
        checks++; if (out_valid !== 1'b1)   begin errors++; $display("[TB] FAIL gaps_out_valid got %b want 1", out_valid); end
        checks++; if (out_sum !== 16'h001A) begin errors++; $display("[TB] FAIL gaps_sum got %h want 001a", out_sum); end
        take_result();
    endtask

    task automatic test_out_stall();
        pulse_start();
        send(16'h0100, 0);
        send(16'h0020, 0);
        send(16'h0003, 0);
        send(16'h4000, 0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            checks++; if (out_valid !== 1'b1 || out_sum !== 16'h4123)
                begin errors++; $display("[TB] FAIL stall_hold cyc %0d got valid=%b sum=%h want valid=1 sum=4123", i, out_valid, out_sum); end
        end
        start = 1'b0;
        take_result();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL stall_release got busy=%b valid=%b want 0 0", busy, out_valid); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_start_ignored busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send(16'h1000, 0);
        send(16'h2000, 0);
        checks++; if (busy !== 1'b1 || out_sum !== 16'h3000)
            begin errors++; $display("[TB] FAIL midreset_pre got busy=%b sum=%h want 1 3000", busy, out_sum); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid, busy, out_carry} !== 4'b0 || out_sum !== 16'h0)
            begin errors++; $display("[TB] FAIL midreset_async got rdy=%b val=%b busy=%b c=%b sum=%h want all 0", in_ready, out_valid, busy, out_carry, out_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_start();
        for (int i = 0; i < 4; i++) send(16'd1, 0);
        checks++; if (out_valid !== 1'b1 || out_sum !== 16'h0004)
            begin errors++; $display("[TB] FAIL midreset_after got valid=%b sum=%h want 1 0004", out_valid, out_sum); end
        take_result();
    endtask

    task automatic test_burst1();
        s1_start    = 1'b1;
        s1_in_valid = 1'b1;
        s1_in_data  = 16'h00FF;
        tick();
        s1_start = 1'b0;
        checks++; if (s1_in_ready !== 1'b1 || s1_out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL burst1_idle_not_consumed got rdy=%b val=%b want 1 0", s1_in_ready, s1_out_valid); end
        tick();
        s1_in_valid = 1'b0;
        checks++; if (s1_out_valid !== 1'b1 || s1_out_sum !== 16'h00FF || s1_out_carry !== 1'b0)
            begin errors++; $display("[TB] FAIL burst1_result got val=%b sum=%h c=%b want 1 00ff 0", s1_out_valid, s1_out_sum, s1_out_carry); end
        s1_out_ready = 1'b1;
        tick();
        s1_out_ready = 1'b0;
        checks++; if (s1_busy !== 1'b0) begin errors++; $display("[TB] FAIL burst1_release busy got %b want 0", s1_busy); end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic [15:0] exp_sum;
        logic        exp_c;
        for (int b = 0; b < 8; b++) begin
            q.delete();
            for (int i = 0; i < 4; i++) q.push_back(16'($urandom));
            model(q, exp_sum, exp_c);
            pulse_start();
            foreach (q[i]) send(q[i], int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 3)) tick();
            checks++; if (out_valid !== 1'b1 || out_sum !== exp_sum || out_carry !== exp_c)
                begin errors++; $display("[TB] FAIL random_burst %0d got val=%b sum=%h c=%b want 1 %h %b", b, out_valid, out_sum, out_carry, exp_sum, exp_c); end
            take_result();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL random_release %0d valid got %b want 0", b, out_valid); end
        end
    endtask

    initial begin
        start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s1_start = 1'b0; s1_in_valid = 1'b0; s1_in_data = '0; s1_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_gaps();
        test_out_stall();
        test_reset_mid();
        test_burst1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
